// File: rtl/vram_arbiter_if.sv
// Host-side request/acknowledge bus of the video RAM arbiter.
// The host drives a request and holds it, together with direction, address
// and write data, until the arbiter answers with a one-cycle acknowledge.
interface vram_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 8
);
    logic          i_host_req;
    logic          i_host_we;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_wdata;
    logic          o_host_ack;
    logic [DW-1:0] o_host_rdata;

    modport master (
        output i_host_req,
        output i_host_we,
        output i_host_addr,
        output i_host_wdata,
        input  o_host_ack,
        input  o_host_rdata
    );

    modport slave (
        input  i_host_req,
        input  i_host_we,
        input  i_host_addr,
        input  i_host_wdata,
        output o_host_ack,
        output o_host_rdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display prefetch FIFO versus host port.
// The display stream has absolute priority while its occupancy (FIFO entries
// plus reads still travelling through the RAM) is below the low watermark;
// otherwise a pending host access goes first, and idle slots top up the FIFO.
// A RAM access registered at one edge returns its data one cycle later, so a
// display read stays in flight for two cycles before it lands in the FIFO.
module vram_arbiter #(
    parameter int AW           = 19,
    parameter int DW           = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOW_WM       = 2,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_frame_start,
    input  logic          i_disp_pop,
    output logic [DW-1:0] o_disp_data,
    output logic          o_disp_valid,
    output logic          o_underrun,
    vram_arbiter_if.slave host,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] LOW_WM_C  = OW'(LOW_WM);
    localparam logic [OW-1:0] DEPTH_C   = OW'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_HOST
    } gnt_t;

    gnt_t          gnt;
    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] occ;
    logic [AW-1:0] disp_addr;
    logic          disp_vld_p0;
    logic          disp_vld_p1;
    logic          host_vld_p0;
    logic          host_busy;
    logic          host_req_ok;
    logic          push;
    logic          pop_ok;
    logic [DW-1:0] host_rdata_q;

    assign occ          = OW'(count) + OW'(disp_vld_p0) + OW'(disp_vld_p1);
    assign host_busy    = host_vld_p0 | host.o_host_ack;
    assign host_req_ok  = host.i_host_req & ~host_busy;
    assign push         = disp_vld_p1 & ~i_frame_start;
    assign pop_ok       = i_disp_pop & (count != '0) & ~i_frame_start;
    assign o_disp_valid = (count != '0);
    assign o_disp_data  = o_disp_valid ? fifo_mem[rd_ptr] : '0;
    assign host.o_host_rdata = host.o_host_ack ? i_ram_rdata : host_rdata_q;

    // Grant selection: the first matching rule wins this cycle
    always_comb begin
        gnt = GNT_IDLE;
        if (i_frame_start) begin
            if (host_req_ok) gnt = GNT_HOST;
        end else if (occ < LOW_WM_C) begin
            gnt = GNT_DISP;
        end else if (host_req_ok) begin
            gnt = GNT_HOST;
        end else if (occ < DEPTH_C) begin
            gnt = GNT_DISP;
        end
    end

    // RAM port registers: one access per cycle, address/data held when idle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_ram_en    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
        end else begin
            o_ram_en <= (gnt != GNT_IDLE);
            o_ram_we <= (gnt == GNT_HOST) && host.i_host_we;
            if (gnt == GNT_HOST) begin
                o_ram_addr  <= host.i_host_addr;
                o_ram_wdata <= host.i_host_wdata;
            end else if (gnt == GNT_DISP) begin
                o_ram_addr <= disp_addr;
            end
        end
    end

    // In-flight tracking: display reads land two edges after grant, host acks one
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            disp_vld_p0     <= 1'b0;
            disp_vld_p1     <= 1'b0;
            host_vld_p0     <= 1'b0;
            host.o_host_ack <= 1'b0;
            host_rdata_q    <= '0;
        end else begin
            disp_vld_p0     <= (gnt == GNT_DISP);
            disp_vld_p1     <= disp_vld_p0 & ~i_frame_start;
            host_vld_p0     <= (gnt == GNT_HOST);
            host.o_host_ack <= host_vld_p0;
            if (host.o_host_ack) host_rdata_q <= i_ram_rdata;
        end
    end

    // Display raster address: restarts on frame start, wraps at frame end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            disp_addr <= '0;
        end else if (i_frame_start) begin
            disp_addr <= '0;
        end else if (gnt == GNT_DISP) begin
            disp_addr <= (disp_addr == LAST_ADDR) ? '0 : disp_addr + AW'(1);
        end
    end

    // FIFO control: flush on frame start, otherwise push/pop with sticky underrun
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_underrun <= 1'b0;
        end else if (i_frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_disp_pop && (count == '0)) o_underrun <= 1'b1;
        end
    end

    // FIFO storage: pixel data only, no reset needed
    always_ff @(posedge i_clock) begin
        if (push) fifo_mem[wr_ptr] <= i_ram_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter with a queue-based reference model of
// the grant rules, prefetch FIFO and host handshake, plus a RAM model.
module tb_vram_arbiter;
    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int FD  = 4;
    localparam int LWM = 2;
    localparam int FP  = 37;

    logic          i_clock;
    logic          i_reset;
    logic          i_frame_start;
    logic          i_disp_pop;
    logic [DW-1:0] o_disp_data;
    logic          o_disp_valid;
    logic          o_underrun;
    logic          o_ram_en;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_rdata;

    vram_arbiter_if #(.AW(AW), .DW(DW)) hbus ();

    vram_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .LOW_WM(LWM), .FRAME_PIXELS(FP)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_frame_start(i_frame_start),
        .i_disp_pop   (i_disp_pop),
        .o_disp_data  (o_disp_data),
        .o_disp_valid (o_disp_valid),
        .o_underrun   (o_underrun),
        .host         (hbus.slave),
        .o_ram_en     (o_ram_en),
        .o_ram_we     (o_ram_we),
        .o_ram_addr   (o_ram_addr),
        .o_ram_wdata  (o_ram_wdata),
        .i_ram_rdata  (i_ram_rdata)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] mem_init(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // RAM model: synchronous single port, read data one cycle after access
    logic [7:0] ram_mem [0:511];
    always @(posedge i_clock) begin
        if (o_ram_en && o_ram_we) ram_mem[o_ram_addr[8:0]] <= o_ram_wdata;
        if (o_ram_en && !o_ram_we) i_ram_rdata <= ram_mem[o_ram_addr[8:0]];
        else                       i_ram_rdata <= 8'($urandom);
    end

    // Reference model state
    typedef struct { logic [7:0] d; int at; } infl_t;
    typedef struct { bit we; logic [AW-1:0] a; logic [7:0] d; } hop_t;

    logic [7:0] mmem [0:511];
    logic [7:0] mfifo [$];
    infl_t      minfl [$];
    hop_t       hq [$];
    hop_t       cur;
    int         edge_n, m_daddr, m_ack_edge, m_busy_until;
    bit         m_underrun, m_ack_we, h_active;
    bit         pw_valid;
    int         pw_addr;
    logic [7:0] pw_data, m_hrdata, last_rd;
    bit         e_en, e_we, e_ack;
    logic [AW-1:0] e_addr;
    logic [7:0] e_wdata;
    int         n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        mfifo.delete();
        minfl.delete();
        m_daddr      = 0;
        m_underrun   = 0;
        m_ack_edge   = -10;
        m_busy_until = -10;
        pw_valid     = 0;
        h_active     = 0;
        e_en = 0; e_we = 0; e_ack = 0;
        hbus.i_host_req = 1'b0;
    endtask

    // One clock edge of the reference: grant rules, FIFO, host timing
    task automatic model_edge();
        int occ, g;
        bit busy, req;
        infl_t t;
        edge_n++;
        if (pw_valid) begin mmem[pw_addr] = pw_data; pw_valid = 0; end
        occ  = mfifo.size() + minfl.size();
        busy = (edge_n <= m_busy_until);
        req  = hbus.i_host_req && !busy;
        g = 0;
        if (i_frame_start) begin if (req) g = 2; end
        else if (occ < LWM) g = 1;
        else if (req) g = 2;
        else if (occ < FD) g = 1;
        if (i_frame_start) begin
            mfifo.delete();
            minfl.delete();
            m_daddr = 0;
        end else begin
            if (i_disp_pop) begin
                if (mfifo.size() == 0) m_underrun = 1;
                else void'(mfifo.pop_front());
            end
            if (minfl.size() > 0 && minfl[0].at == edge_n) begin
                t = minfl.pop_front();
                mfifo.push_back(t.d);
            end
        end
        e_en = (g != 0);
        e_we = 0;
        if (g == 1) begin
            e_addr = AW'(m_daddr);
            t.d = mmem[m_daddr];
            t.at = edge_n + 2;
            minfl.push_back(t);
            m_daddr = (m_daddr == FP - 1) ? 0 : m_daddr + 1;
        end else if (g == 2) begin
            e_addr  = hbus.i_host_addr;
            e_we    = hbus.i_host_we;
            e_wdata = hbus.i_host_wdata;
            if (e_we) begin
                pw_valid = 1; pw_addr = int'(e_addr[8:0]); pw_data = e_wdata;
            end else begin
                m_hrdata = mmem[e_addr[8:0]];
            end
            m_ack_we     = e_we;
            m_ack_edge   = edge_n + 1;
            m_busy_until = edge_n + 2;
        end
        e_ack = (edge_n == m_ack_edge);
        if (h_active && edge_n == m_ack_edge + 1) h_active = 0;
    endtask

    task automatic compare();
        logic [7:0] xd;
        xd = (mfifo.size() > 0) ? mfifo[0] : 8'h00;
        chk("disp_valid", 32'(o_disp_valid), 32'(mfifo.size() > 0));
        chk("disp_data", 32'(o_disp_data), 32'(xd));
        chk("underrun", 32'(o_underrun), 32'(m_underrun));
        chk("ram_en", 32'(o_ram_en), 32'(e_en));
        if (e_en) begin
            chk("ram_we", 32'(o_ram_we), 32'(e_we));
            chk("ram_addr", 32'(o_ram_addr), 32'(e_addr));
            if (e_we) chk("ram_wdata", 32'(o_ram_wdata), 32'(e_wdata));
        end
        chk("host_ack", 32'(hbus.o_host_ack), 32'(e_ack));
        if (e_ack && !m_ack_we) begin
            chk("host_rdata", 32'(hbus.o_host_rdata), 32'(m_hrdata));
            last_rd = hbus.o_host_rdata;
        end
    endtask

    task automatic reset_chk();
        chk("rst_ram_en", 32'(o_ram_en), 32'd0);
        chk("rst_ram_we", 32'(o_ram_we), 32'd0);
        chk("rst_ram_addr", 32'(o_ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(o_ram_wdata), 32'd0);
        chk("rst_disp_valid", 32'(o_disp_valid), 32'd0);
        chk("rst_disp_data", 32'(o_disp_data), 32'd0);
        chk("rst_underrun", 32'(o_underrun), 32'd0);
        chk("rst_host_ack", 32'(hbus.o_host_ack), 32'd0);
        chk("rst_host_rdata", 32'(hbus.o_host_rdata), 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked before any edge
    task automatic mid_reset();
        i_reset = 1'b1;
        #1;
        reset_chk();
        model_reset();
        i_disp_pop = 1'b0;
        i_frame_start = 1'b0;
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge, then step and compare
    task automatic drive(input int p_pop, input int p_req, input int p_fs, input bit f_fs);
        i_disp_pop    = ($urandom_range(0, 99) < p_pop);
        i_frame_start = f_fs || ($urandom_range(0, 99) < p_fs);
        if (!h_active) begin
            if (hq.size() > 0) begin
                cur = hq.pop_front();
                h_active = 1;
            end else if ($urandom_range(0, 99) < p_req) begin
                cur.we = 1'($urandom_range(0, 1));
                cur.a  = ($urandom_range(0, 7) == 0) ? AW'(32'h100) : AW'($urandom_range(0, 47));
                cur.d  = 8'($urandom);
                h_active = 1;
            end
        end
        hbus.i_host_req   = h_active;
        hbus.i_host_we    = cur.we;
        hbus.i_host_addr  = cur.a;
        hbus.i_host_wdata = cur.d;
        @(posedge i_clock);
        model_edge();
        #1;
        compare();
        @(negedge i_clock);
    endtask

    initial begin
        hop_t op;
        n_chk = 0; n_err = 0; edge_n = 0; last_rd = 8'h00;
        cur = '{we: 1'b0, a: '0, d: 8'h00};
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = mem_init(i);
            mmem[i]    = mem_init(i);
        end
        i_reset = 1'b0; i_frame_start = 1'b0; i_disp_pop = 1'b0;
        hbus.i_host_req = 1'b0; hbus.i_host_we = 1'b0;
        hbus.i_host_addr = '0; hbus.i_host_wdata = '0;
        model_reset();
        #1 i_reset = 1'b1;
        #1 reset_chk();
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;

        // Pop while empty, then idle prefill to full
        drive(100, 0, 0, 0);
        repeat (8) drive(0, 0, 0, 0);

        // FIFO full: host write 0x100 = A5, then read it back
        op = '{we: 1'b1, a: AW'(32'h100), d: 8'hA5};
        hq.push_back(op);
        op.we = 1'b0; op.d = 8'h00;
        hq.push_back(op);
        repeat (10) drive(0, 0, 0, 0);
        chk("wr_rd_0x100", 32'(last_rd), 32'h0000_00A5);

        // Underrun survives a frame start
        drive(0, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0);

        // Reset mid-stream; frame start with pop on empty FIFO is not an underrun
        mid_reset();
        drive(100, 0, 0, 1);
        repeat (6) drive(0, 0, 0, 0);

        // Continuous pop with continuous host traffic, frame start in the middle
        for (int i = 0; i < 40; i++) drive(100, 100, 0, i == 20);

        // Long random run covering address wrap and another async reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            drive(60, 40, 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
